// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush controller for the four inter-stage pipeline registers
// (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each stage register gets a write
// enable and a flush; a flushed stage register loads an all-zero bubble.
//
// Hazards, highest priority first:
//   1. data-memory wait      - freeze the whole pipe (FSM and mc counter too)
//   2. multicycle op waiting - hold IF/ID, ID/EX; bubble into EX/MEM
//   3. branch redirect       - squash IF/ID and ID/EX
//   4. multicycle op start   - same stall pattern as 2, enter MC_WAIT
//   5. load-use              - hold PC, IF/ID; bubble into ID/EX
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   i_id_rs1/rs2       source registers of the ID instruction
//   i_id_uses_rs1/rs2  ID instruction actually reads that source
//   i_ex_is_load       EX instruction is a load
//   i_ex_rd            destination register of the EX instruction
//   i_ex_mc_start      EX holds a multicycle op (held high while in EX)
//   i_branch_taken     EX resolved a redirect
//   i_mem_req          MEM stage accesses data memory
//   i_mem_ready        data memory completes the access this cycle
//   o_pc_en            PC write enable
//   o_stage_en[3:0]    stage register write enables (bit 0 = IF/ID)
//   o_stage_flush[3:0] stage register bubble insert
//   o_mc_busy          FSM is in MC_WAIT
//   o_stall_cnt        saturating count of cycles with o_pc_en = 0
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mc_start,
  input  logic                  i_branch_taken,
  input  logic                  i_mem_req,
  input  logic                  i_mem_ready,
  output logic                  o_pc_en,
  output logic [3:0]            o_stage_en,
  output logic [3:0]            o_stage_flush,
  output logic                  o_mc_busy,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  if (MC_LATENCY < 2) begin : g_latency_check
    $error("pipeline_hazard_ctrl: MC_LATENCY must be >= 2");
  end

  localparam int MC_CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

  // Enable/flush patterns shared by the hazard cases.
  localparam logic [3:0] EN_ALL      = 4'b1111;
  localparam logic [3:0] EN_NONE     = 4'b0000;
  localparam logic [3:0] EN_MC       = 4'b1100;
  localparam logic [3:0] FLUSH_MC    = 4'b0100;
  localparam logic [3:0] EN_LU       = 4'b1110;
  localparam logic [3:0] FLUSH_LU    = 4'b0010;
  localparam logic [3:0] FLUSH_BR    = 4'b0011;
  localparam logic [3:0] FLUSH_NONE  = 4'b0000;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  state_t                state_r;
  state_t                nxt_state_s;
  logic [MC_CNT_W-1:0]   mc_cnt_r;
  logic [MC_CNT_W-1:0]   nxt_mc_cnt_s;
  logic [CNT_W-1:0]      stall_cnt_r;

  logic                  mem_stall_s;
  logic                  rs1_hit_s;
  logic                  rs2_hit_s;
  logic                  load_use_s;
  logic                  pc_en_s;
  logic [3:0]            stage_en_s;
  logic [3:0]            stage_flush_s;

  // Hazard detection terms; register 0 is hard-wired and never a dependency.
  always_comb begin
    mem_stall_s = i_mem_req & ~i_mem_ready;
    rs1_hit_s   = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    rs2_hit_s   = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    load_use_s  = i_ex_is_load & (i_ex_rd != {REG_ADDR_W{1'b0}}) & (rs1_hit_s | rs2_hit_s);
  end

  // Priority resolution of the hazards into enables, flushes and next state.
  always_comb begin
    pc_en_s       = 1'b1;
    stage_en_s    = EN_ALL;
    stage_flush_s = FLUSH_NONE;
    nxt_state_s   = state_r;
    nxt_mc_cnt_s  = mc_cnt_r;

    if (rst) begin
      pc_en_s       = 1'b0;
      stage_en_s    = EN_NONE;
      stage_flush_s = FLUSH_NONE;
    end else if (mem_stall_s) begin
      // Whole pipe frozen; FSM and mc counter hold their values.
      pc_en_s       = 1'b0;
      stage_en_s    = EN_NONE;
      stage_flush_s = FLUSH_NONE;
    end else if (state_r == ST_MC_WAIT) begin
      if (mc_cnt_r != {MC_CNT_W{1'b0}}) begin
        pc_en_s       = 1'b0;
        stage_en_s    = EN_MC;
        stage_flush_s = FLUSH_MC;
        nxt_mc_cnt_s  = mc_cnt_r - MC_CNT_W'(1'b1);
      end else begin
        // Final cycle of the op: let it advance out of EX.
        nxt_state_s   = ST_RUN;
      end
    end else if (i_branch_taken) begin
      stage_flush_s = FLUSH_BR;
    end else if (i_ex_mc_start) begin
      // Start cycle counts as cycle 1, MC_WAIT covers the remaining cycles.
      pc_en_s       = 1'b0;
      stage_en_s    = EN_MC;
      stage_flush_s = FLUSH_MC;
      nxt_mc_cnt_s  = MC_CNT_W'(MC_LATENCY - 2);
      nxt_state_s   = ST_MC_WAIT;
    end else if (load_use_s) begin
      pc_en_s       = 1'b0;
      stage_en_s    = EN_LU;
      stage_flush_s = FLUSH_LU;
    end else begin
      pc_en_s       = 1'b1;
      stage_en_s    = EN_ALL;
      stage_flush_s = FLUSH_NONE;
    end
  end

  // FSM state and multicycle countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_RUN;
      mc_cnt_r <= {MC_CNT_W{1'b0}};
    end else begin
      state_r  <= nxt_state_s;
      mc_cnt_r <= nxt_mc_cnt_s;
    end
  end

  // Saturating stalled-cycle performance counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!pc_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Output drive; busy is forced low while reset is applied.
  always_comb begin
    o_pc_en       = pc_en_s;
    o_stage_en    = stage_en_s;
    o_stage_flush = stage_flush_s;
    o_mc_busy     = (state_r == ST_MC_WAIT) & ~rst;
    o_stall_cnt   = stall_cnt_r;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Two instances share all inputs: dut_a with CNT_W = 16, dut_b with CNT_W = 2
// (saturation). A behavioural model tracks how many cycles the multicycle op
// has spent in EX and derives the expected outputs from the hazard priority
// list; a negedge process compares both instances against it every cycle.
// Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          uses_rs1, uses_rs2, ex_is_load, mc_start, branch, mem_req, mem_ready;

  logic          a_pc_en, b_pc_en, a_busy, b_busy;
  logic [3:0]    a_en, a_fl, b_en, b_fl;
  logic [15:0]   a_cnt;
  logic [1:0]    b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MC_LATENCY(LAT), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(uses_rs1), .i_id_uses_rs2(uses_rs2), .i_ex_is_load(ex_is_load),
    .i_ex_rd(ex_rd), .i_ex_mc_start(mc_start), .i_branch_taken(branch),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready), .o_pc_en(a_pc_en),
    .o_stage_en(a_en), .o_stage_flush(a_fl), .o_mc_busy(a_busy), .o_stall_cnt(a_cnt)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MC_LATENCY(LAT), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(uses_rs1), .i_id_uses_rs2(uses_rs2), .i_ex_is_load(ex_is_load),
    .i_ex_rd(ex_rd), .i_ex_mc_start(mc_start), .i_branch_taken(branch),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready), .o_pc_en(b_pc_en),
    .o_stage_en(b_en), .o_stage_flush(b_fl), .o_mc_busy(b_busy), .o_stall_cnt(b_cnt)
  );

  // ---------------- behavioural model ----------------
  // m_active: a multicycle op occupies EX; m_age: cycles it has already spent there.
  logic       m_active;
  int         m_age;
  int         m_cnt_a, m_cnt_b;
  logic       exp_pc_en, exp_busy, nxt_active, hit;
  logic [3:0] exp_en, exp_fl;
  int         nxt_age;

  // Expected outputs this cycle from the priority list.
  always_comb begin
    exp_pc_en  = 1'b1;
    exp_en     = 4'hF;
    exp_fl     = 4'h0;
    exp_busy   = m_active;
    nxt_active = m_active;
    nxt_age    = m_age;
    hit = ex_is_load && (ex_rd != 0) &&
          ((uses_rs1 && id_rs1 == ex_rd) || (uses_rs2 && id_rs2 == ex_rd));
    if (rst) begin
      exp_pc_en = 1'b0; exp_en = 4'h0; exp_fl = 4'h0; exp_busy = 1'b0;
    end else if (mem_req && !mem_ready) begin
      exp_pc_en = 1'b0; exp_en = 4'h0; exp_fl = 4'h0;
    end else if (m_active) begin
      nxt_age = m_age + 1;
      if (m_age + 1 < LAT) begin
        exp_pc_en = 1'b0; exp_en = 4'b1100; exp_fl = 4'b0100;
      end else begin
        nxt_active = 1'b0;
      end
    end else if (branch) begin
      exp_fl = 4'b0011;
    end else if (mc_start) begin
      nxt_active = 1'b1; nxt_age = 1;
      exp_pc_en = 1'b0; exp_en = 4'b1100; exp_fl = 4'b0100;
    end else if (hit) begin
      exp_pc_en = 1'b0; exp_en = 4'b1110; exp_fl = 4'b0010;
    end else begin
      exp_pc_en = 1'b1;
    end
  end

  // Model state update.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_age <= 0; m_cnt_a <= 0; m_cnt_b <= 0;
    end else begin
      m_active <= nxt_active;
      m_age    <= nxt_age;
      if (!exp_pc_en) begin
        m_cnt_a <= (m_cnt_a < 65535) ? m_cnt_a + 1 : m_cnt_a;
        m_cnt_b <= (m_cnt_b < 3) ? m_cnt_b + 1 : m_cnt_b;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("a_pc_en", 32'(a_pc_en), 32'(exp_pc_en));
    check("a_stage_en", 32'(a_en), 32'(exp_en));
    check("a_stage_flush", 32'(a_fl), 32'(exp_fl));
    check("a_mc_busy", 32'(a_busy), 32'(exp_busy));
    check("a_stall_cnt", 32'(a_cnt), m_cnt_a);
    check("b_pc_en", 32'(b_pc_en), 32'(exp_pc_en));
    check("b_stage_en", 32'(b_en), 32'(exp_en));
    check("b_mc_busy", 32'(b_busy), 32'(exp_busy));
    check("b_stall_cnt", 32'(b_cnt), m_cnt_b);
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; uses_rs1 = 1'b0; uses_rs2 = 1'b0;
    ex_is_load = 1'b0; mc_start = 1'b0; branch = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [AW-1:0] rd, input logic [AW-1:0] r1, input logic u1,
                          input logic [AW-1:0] r2, input logic u2, input logic ld);
    ex_rd = rd; id_rs1 = r1; uses_rs1 = u1; id_rs2 = r2; uses_rs2 = u2; ex_is_load = ld;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    check("rst_pc_en", 32'(a_pc_en), 32'd0);
    check("rst_stage_en", 32'(a_en), 32'd0);
    check("rst_stall_cnt", 32'(a_cnt), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1. plain flow
    repeat (5) tick();
    check("flow_stage_en", 32'(a_en), 32'hF);
    check("flow_stall_cnt", 32'(a_cnt), 32'd0);

    // 2. load-use on rs2, then rd = 0 never stalls
    load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    check("lu_pc_en", 32'(a_pc_en), 32'd0);
    check("lu_stage_en", 32'(a_en), 32'b1110);
    check("lu_stage_flush", 32'(a_fl), 32'b0010);
    tick();
    check("lu_stall_cnt", 32'(a_cnt), 32'd1);
    load_use(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    #1;
    check("lu_rd0_pc_en", 32'(a_pc_en), 32'd1);
    tick();
    load_use(5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1);  // rs1 matches but unused
    tick();
    load_use(5'd7, 5'd7, 1'b1, 5'd3, 1'b0, 1'b1);  // rs1 matches and used
    tick();
    load_use(5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);  // not a load
    tick();
    idle();
    check("lu_tbl_stall_cnt", 32'(a_cnt), 32'd2);

    // 3. multicycle op, held in EX for LAT cycles
    mc_start = 1'b1;
    #1;
    check("mc_c1_stage_en", 32'(a_en), 32'b1100);
    check("mc_c1_busy", 32'(a_busy), 32'd0);
    tick();
    check("mc_c2_busy", 32'(a_busy), 32'd1);
    tick();
    tick();
    check("mc_c4_stage_en", 32'(a_en), 32'hF);
    check("mc_c4_pc_en", 32'(a_pc_en), 32'd1);
    tick();
    mc_start = 1'b0;
    #1;
    check("mc_done_busy", 32'(a_busy), 32'd0);
    check("mc_stall_cnt", 32'(a_cnt), 32'd5);

    // 4. branch together with load-use: branch wins
    branch = 1'b1;
    load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
    #1;
    check("br_stage_en", 32'(a_en), 32'hF);
    check("br_stage_flush", 32'(a_fl), 32'b0011);
    check("br_pc_en", 32'(a_pc_en), 32'd1);
    tick();
    // memory wait overrides branch in RUN
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    check("mem_br_stage_en", 32'(a_en), 32'd0);
    tick();
    mem_ready = 1'b1;
    tick();
    idle();
    check("br_stall_cnt", 32'(a_cnt), 32'd6);

    // 5. memory wait during MC_WAIT with one countdown step left
    mc_start = 1'b1;
    tick();
    tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (3) begin
      #1;
      check("mcmem_stage_en", 32'(a_en), 32'd0);
      check("mcmem_busy", 32'(a_busy), 32'd1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("mcmem_resume_en", 32'(a_en), 32'b1100);
    tick();
    check("mcmem_last_en", 32'(a_en), 32'hF);
    tick();
    idle();
    check("mcmem_stall_cnt", 32'(a_cnt), 32'd12);

    // 6. saturation of the narrow counter, then async reset mid-MC_WAIT
    check("sat_b_stall_cnt", 32'(b_cnt), 32'd3);
    mc_start = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(a_busy), 32'd0);
    check("arst_pc_en", 32'(a_pc_en), 32'd0);
    check("arst_stage_en", 32'(a_en), 32'd0);
    check("arst_stall_cnt", 32'(a_cnt), 32'd0);
    check("arst_b_stall_cnt", 32'(b_cnt), 32'd0);
    tick();
    idle();
    rst = 1'b0;
    #1;
    check("post_rst_pc_en", 32'(a_pc_en), 32'd1);
    check("post_rst_busy", 32'(a_busy), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the processor's four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Drives each stage register's write enable and a per-stage flush. Flush means the stage register loads a bubble (all-zero) instead of its input.
- Resolves four hazards: data-memory wait, branch redirect, fixed-latency multicycle EX ops, and load-use.
- Keeps a saturating stalled-cycle performance counter.

Parameters:
REG_ADDR_W, 5, width of register-file addresses.
MC_LATENCY, 4, total cycles a multicycle op occupies EX. Must be >= 2; elaboration error otherwise.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_id_rs1  in  REG_ADDR_W  source reg 1 of the instruction in ID
i_id_rs2  in  REG_ADDR_W  source reg 2 of the instruction in ID
i_id_uses_rs1  in  1  ID instruction reads rs1
i_id_uses_rs2  in  1  ID instruction reads rs2
i_ex_is_load  in  1  EX instruction is a load
i_ex_rd  in  REG_ADDR_W  destination reg of the EX instruction
i_ex_mc_start  in  1  EX holds a multicycle op; stays high while that op is held in EX
i_branch_taken  in  1  EX resolved a redirect (taken branch or jump)
i_mem_req  in  1  MEM stage is accessing data memory
i_mem_ready  in  1  data memory completes the access this cycle
o_pc_en  out  1  PC write enable
o_stage_en  out  4  write enable per stage register; bit 0 = IF/ID ... bit 3 = MEM/WB
o_stage_flush  out  4  bubble insert per stage register; only meaningful with the matching enable
o_mc_busy  out  1  FSM is in MC_WAIT
o_stall_cnt  out  CNT_W  saturating count of cycles with o_pc_en = 0

Behaviour:
- Registered state: FSM {RUN, MC_WAIT}, mc_cnt (clog2(MC_LATENCY) bits), stall counter. All other outputs are combinational from state and inputs.
- Reset: FSM = RUN, mc_cnt = 0, o_stall_cnt = 0.
- While rst is high: o_pc_en = 0, o_stage_en = 0, o_stage_flush = 0, o_mc_busy = 0.
- Default, RUN with no hazard: o_pc_en = 1, o_stage_en = 4'b1111, o_stage_flush = 0.
- Conditions are evaluated in strict priority order, highest first:
  1. MEM_STALL (i_mem_req & ~i_mem_ready, any state): o_pc_en = 0, o_stage_en = 0, o_stage_flush = 0. FSM and mc_cnt are frozen. Overrides everything below.
  2. MC_WAIT state:
     - mc_cnt != 0: o_pc_en = 0; en[0] = en[1] = 0; en[2] = 1 with flush[2] = 1 (bubble into EX/MEM); en[3] = 1; mc_cnt decrements.
     - mc_cnt == 0: default advance, FSM -> RUN.
     - i_branch_taken and i_ex_mc_start are ignored in this state.
  3. BRANCH (RUN & i_branch_taken): default enables, flush[0] = flush[1] = 1. One cycle only, no state change. Wins over MC start and load-use.
  4. MC_START (RUN & i_ex_mc_start): same outputs as the MC_WAIT stall pattern; mc_cnt <= MC_LATENCY-2; FSM -> MC_WAIT. The op leaves EX at the end of cycle MC_LATENCY, counting the start cycle as cycle 1.
  5. LOAD_USE (RUN & i_ex_is_load & i_ex_rd != 0 & ((i_id_uses_rs1 & i_id_rs1 == i_ex_rd) | (i_id_uses_rs2 & i_id_rs2 == i_ex_rd))): o_pc_en = 0, en[0] = 0, en[1] = 1 with flush[1] = 1, en[2] = en[3] = 1. Single cycle, no state.
- o_mc_busy = (FSM == MC_WAIT).
- o_stall_cnt increments on each cycle where o_pc_en = 0 and rst = 0. It saturates at all-ones and never wraps.
- Reset asserted mid-MC_WAIT or mid-memory wait aborts immediately to the reset values; no pending op is remembered.
- Register address 0 never causes a load-use stall.

Test Plan:
1. Plain flow: no hazards for 5 cycles after reset -> o_pc_en = 1, o_stage_en = 4'hF, o_stage_flush = 0, o_stall_cnt = 0 throughout.
2. Load-use: i_ex_is_load = 1, i_ex_rd = 5, i_id_rs2 = 5, uses_rs2 = 1 for 1 cycle -> o_pc_en = 0, o_stage_en = 4'b1110, o_stage_flush = 4'b0010, o_stall_cnt = 1. Repeat with i_ex_rd = 0 -> no stall.
3. Multicycle: i_ex_mc_start held high, MC_LATENCY = 4 -> 3 cycles of o_pc_en = 0, o_stage_en = 4'b1100, o_stage_flush = 4'b0100, o_mc_busy = 1 (for the last 2 of those 3 cycles); 4th cycle en = 4'hF; FSM = RUN; o_stall_cnt = 3.
4. Branch + load-use in the same cycle -> branch wins: o_stage_en = 4'hF, o_stage_flush = 4'b0011, o_pc_en = 1, no stall counted.
5. Memory wait: i_mem_req = 1, i_mem_ready = 0 for 3 cycles during MC_WAIT (mc_cnt = 1) -> en = 0 and mc_cnt stays 1 for those 3 cycles; after ready, the MC sequence resumes with 2 more cycles to completion.
6. Saturation/reset: CNT_W = 2, force 5 stall cycles -> o_stall_cnt = 3. Assert rst asynchronously mid-MC_WAIT -> outputs return to reset values immediately, FSM = RUN.
